// File: rtl/oai222_chk_pkg.sv
// Shared definitions for the OAI222 exhaustive checker: vector geometry,
// sequencer states and the golden cell function.
package oai222_chk_pkg;

  localparam int VEC_W   = 6;
  localparam int NUM_VEC = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } chk_state_e;

  // vec = {A1,A2,B1,B2,C1,C2}
  function automatic logic golden_oai222(input logic [VEC_W-1:0] vec);
    return ~((vec[5] | vec[4]) & (vec[3] | vec[2]) & (vec[1] | vec[0]));
  endfunction

endpackage

// File: rtl/oai222_chk_seq.sv
// Vector sequencer: walks all 64 input combinations LOOPS times, holding each
// for SETTLE_CYCLES+1 cycles, and strobes CHECK on the last cycle of each hold.
//
// state  | meaning
// IDLE   | waiting for start_i, stimulus driven to 0
// HOLD   | current vector applied, settle down-counter running
// CHECK  | last cycle of the vector window, ZN compared at the closing edge
// FINISH | run complete, DONE/PASS registered on exit
module oai222_chk_seq
  import oai222_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int LOOPS         = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  output logic             start_acc_o,
  output logic             check_o,
  output logic             finish_o,
  output logic             busy_o,
  output logic [VEC_W-1:0] vec_o
);

  localparam logic [3:0] SETTLE    = 4'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);

  chk_state_e       state_q;
  logic [3:0]       hold_q;
  logic [VEC_W-1:0] vec_q;
  logic [7:0]       loop_q;
  logic             busy_q;
  logic             last_vec;
  chk_state_e       after_vec;

  assign last_vec  = (vec_q == 6'h3F) && (loop_q == LAST_LOOP);
  // With no settle time the hold phase collapses and CHECK follows directly.
  assign after_vec = (SETTLE == 4'd0) ? CHECK : HOLD;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      hold_q  <= 4'd0;
      vec_q   <= '0;
      loop_q  <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            vec_q   <= '0;
            loop_q  <= 8'd0;
            hold_q  <= SETTLE;
            busy_q  <= 1'b1;
            state_q <= after_vec;
          end
        end
        HOLD: begin
          if (hold_q <= 4'd1) begin
            state_q <= CHECK;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        CHECK: begin
          if (last_vec) begin
            vec_q   <= '0;
            loop_q  <= 8'd0;
            state_q <= FINISH;
          end else begin
            vec_q   <= vec_q + 6'd1;
            if (vec_q == 6'h3F) begin
              loop_q <= loop_q + 8'd1;
            end
            hold_q  <= SETTLE;
            state_q <= after_vec;
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_acc_o = (state_q == IDLE) && start_i;
  assign check_o     = (state_q == CHECK);
  assign finish_o    = (state_q == FINISH);
  assign busy_o      = busy_q;
  assign vec_o       = vec_q;

endmodule

// File: rtl/oai222_exhaustive_checker.sv
// OAI222 exhaustive checker top: drives the cell stimulus from the sequencer,
// compares ZN against the golden function and keeps the run result registers.
module oai222_exhaustive_checker
  import oai222_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int LOOPS         = 1,
  parameter int CNT_W         = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             C1,
  output logic             C2,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             FAIL_VALID,
  output logic [VEC_W-1:0] FIRST_FAIL
);

  logic             start_acc;
  logic             check;
  logic             finish;
  logic             busy;
  logic [VEC_W-1:0] vec;
  logic             mismatch;

  logic [CNT_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [VEC_W-1:0] ff_q, ff_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;

  oai222_chk_seq #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .LOOPS         (LOOPS)
  ) u_seq (
    .clk_i       (CLK),
    .rst_n_i     (RN),
    .start_i     (START),
    .start_acc_o (start_acc),
    .check_o     (check),
    .finish_o    (finish),
    .busy_o      (busy),
    .vec_o       (vec)
  );

  // Case-inequality so an X or Z on ZN is scored as a failure in simulation.
  assign mismatch = (ZN !== golden_oai222(vec));

  always_comb begin
    err_d  = err_q;
    fv_d   = fv_q;
    ff_d   = ff_q;
    pass_d = pass_q;
    done_d = finish;
    if (start_acc) begin
      err_d  = '0;
      fv_d   = 1'b0;
      ff_d   = '0;
      pass_d = 1'b0;
    end else if (check && mismatch) begin
      if (err_q != '1) begin
        err_d = err_q + CNT_W'(1);
      end
      if (!fv_q) begin
        fv_d = 1'b1;
        ff_d = vec;
      end
    end else if (finish) begin
      pass_d = (err_q == '0);
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      err_q  <= '0;
      fv_q   <= 1'b0;
      ff_q   <= '0;
      pass_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      fv_q   <= fv_d;
      ff_q   <= ff_d;
      pass_q <= pass_d;
      done_q <= done_d;
    end
  end

  assign {A1, A2, B1, B2, C1, C2} = vec;
  assign BUSY       = busy;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign ERR_CNT    = err_q;
  assign FAIL_VALID = fv_q;
  assign FIRST_FAIL = ff_q;

endmodule

// File: tb/tb_oai222_exhaustive_checker.sv
// Self-checking bench for oai222_exhaustive_checker: four configurations, a
// table of DUT behaviours on one instance and hand sequences for the corners.
module tb_oai222_exhaustive_checker;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic [3:0] start_v = 4'b0;
  logic [3:0] done_v;
  logic [3:0] busy_v;
  logic [5:0] stim_v [4];

  // A: S=1 L=1 W=8, selectable ZN model
  logic [5:0] a_stim; logic a_busy, a_done, a_pass, a_fv; logic [7:0] a_err; logic [5:0] a_ff;
  // B: S=1 L=1 W=5, ZN tied 0
  logic [5:0] b_stim; logic b_busy, b_done, b_pass, b_fv; logic [4:0] b_err; logic [5:0] b_ff;
  // C: S=0 L=2 W=8, ideal ZN
  logic [5:0] c_stim; logic c_busy, c_done, c_pass, c_fv; logic [7:0] c_err; logic [5:0] c_ff;
  // D: S=0 L=1 W=8, registered ZN
  logic [5:0] d_stim; logic d_busy, d_done, d_pass, d_fv; logic [7:0] d_err; logic [5:0] d_ff;

  int   mode_a = 0;
  logic zn_a, zn_b, zn_c, zreg_a, zreg_d;

  function automatic logic tb_gold(input logic [5:0] v);
    int pairs;
    pairs = int'(v[5:4] != 2'b00) + int'(v[3:2] != 2'b00) + int'(v[1:0] != 2'b00);
    return (pairs != 3);
  endfunction

  always_ff @(posedge clk) begin
    zreg_a <= tb_gold(a_stim);
    zreg_d <= tb_gold(d_stim);
  end

  always_comb begin
    case (mode_a)
      0:       zn_a = tb_gold(a_stim);
      1:       zn_a = 1'b1;
      2:       zn_a = 1'b0;
      default: zn_a = zreg_a;
    endcase
  end
  assign zn_b = 1'b0;
  assign zn_c = tb_gold(c_stim);

  oai222_exhaustive_checker #(.SETTLE_CYCLES(1), .LOOPS(1), .CNT_W(8)) u_a (
    .CLK(clk), .RN(rn), .START(start_v[0]), .ZN(zn_a),
    .A1(a_stim[5]), .A2(a_stim[4]), .B1(a_stim[3]), .B2(a_stim[2]), .C1(a_stim[1]), .C2(a_stim[0]),
    .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .ERR_CNT(a_err), .FAIL_VALID(a_fv), .FIRST_FAIL(a_ff));

  oai222_exhaustive_checker #(.SETTLE_CYCLES(1), .LOOPS(1), .CNT_W(5)) u_b (
    .CLK(clk), .RN(rn), .START(start_v[1]), .ZN(zn_b),
    .A1(b_stim[5]), .A2(b_stim[4]), .B1(b_stim[3]), .B2(b_stim[2]), .C1(b_stim[1]), .C2(b_stim[0]),
    .BUSY(b_busy), .DONE(b_done), .PASS(b_pass), .ERR_CNT(b_err), .FAIL_VALID(b_fv), .FIRST_FAIL(b_ff));

  oai222_exhaustive_checker #(.SETTLE_CYCLES(0), .LOOPS(2), .CNT_W(8)) u_c (
    .CLK(clk), .RN(rn), .START(start_v[2]), .ZN(zn_c),
    .A1(c_stim[5]), .A2(c_stim[4]), .B1(c_stim[3]), .B2(c_stim[2]), .C1(c_stim[1]), .C2(c_stim[0]),
    .BUSY(c_busy), .DONE(c_done), .PASS(c_pass), .ERR_CNT(c_err), .FAIL_VALID(c_fv), .FIRST_FAIL(c_ff));

  oai222_exhaustive_checker #(.SETTLE_CYCLES(0), .LOOPS(1), .CNT_W(8)) u_d (
    .CLK(clk), .RN(rn), .START(start_v[3]), .ZN(zreg_d),
    .A1(d_stim[5]), .A2(d_stim[4]), .B1(d_stim[3]), .B2(d_stim[2]), .C1(d_stim[1]), .C2(d_stim[0]),
    .BUSY(d_busy), .DONE(d_done), .PASS(d_pass), .ERR_CNT(d_err), .FAIL_VALID(d_fv), .FIRST_FAIL(d_ff));

  assign done_v = {d_done, c_done, b_done, a_done};
  assign busy_v = {d_busy, c_busy, b_busy, a_busy};
  assign stim_v[0] = a_stim;
  assign stim_v[1] = b_stim;
  assign stim_v[2] = c_stim;
  assign stim_v[3] = d_stim;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%h) expected %0d", nm, act, act, exp);
  endtask

  // Pulse START, then count cycles from the accepting edge until DONE.
  task automatic run_dut(input int idx, input int settle, input int exp_lat, input bit extra,
                         output int lat, output int trace_err);
    @(negedge clk); start_v[idx] = 1'b1;
    @(negedge clk); start_v[idx] = 1'b0;
    chk("busy_after_start", 32'(busy_v[idx]), 32'd1);
    lat = 0;
    trace_err = 0;
    while (!done_v[idx] && lat < 400) begin
      if (lat < exp_lat - 1 && stim_v[idx] !== 6'((lat / (settle + 1)) % 64)) trace_err++;
      @(negedge clk);
      start_v[idx] = extra && (lat % 30 == 9) && (lat < exp_lat - 3);
      lat++;
    end
    start_v[idx] = 1'b0;
    chk("done_busy_low", 32'(busy_v[idx]), 32'd0);
    chk("done_stim_zero", 32'(stim_v[idx]), 32'd0);
  endtask

  typedef struct {
    int   mode;
    int   err;
    logic fv;
    int   ff;
    logic pass;
  } row_t;

  row_t rows [4];

  initial begin
    int lat, terr, waited, ndone;

    rows[0] = '{mode: 0, err: 0,  fv: 1'b0, ff: 0,  pass: 1'b1};
    rows[1] = '{mode: 1, err: 27, fv: 1'b1, ff: 21, pass: 1'b0};
    rows[2] = '{mode: 3, err: 0,  fv: 1'b0, ff: 0,  pass: 1'b1};
    rows[3] = '{mode: 2, err: 37, fv: 1'b1, ff: 0,  pass: 1'b0};

    #23;
    chk("reset_a", {a_stim, a_busy, a_done, a_pass, a_err, a_fv, a_ff}, 32'd0);
    chk("reset_b", {b_stim, b_busy, b_done, b_pass, b_err, b_fv, b_ff}, 32'd0);
    chk("reset_c", {c_stim, c_busy, c_done, c_pass, c_err, c_fv, c_ff}, 32'd0);
    chk("reset_d", {d_stim, d_busy, d_done, d_pass, d_err, d_fv, d_ff}, 32'd0);
    @(negedge clk); rn = 1'b1;
    repeat (3) @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      mode_a = rows[r].mode;
      run_dut(0, 1, 129, 1'b0, lat, terr);
      chk("a_latency", 32'(lat), 32'd129);
      chk("a_trace", 32'(terr), 32'd0);
      chk("a_done", 32'(a_done), 32'd1);
      chk("a_err_cnt", 32'(a_err), 32'(rows[r].err));
      chk("a_fail_valid", 32'(a_fv), 32'(rows[r].fv));
      chk("a_first_fail", 32'(a_ff), 32'(rows[r].ff));
      chk("a_pass", 32'(a_pass), 32'(rows[r].pass));
      @(negedge clk);
      chk("a_done_pulse", 32'(a_done), 32'd0);
      chk("a_pass_held", 32'(a_pass), 32'(rows[r].pass));
    end

    // Saturating counter: 37 true mismatches into a 5-bit counter.
    run_dut(1, 1, 129, 1'b0, lat, terr);
    chk("b_latency", 32'(lat), 32'd129);
    chk("b_err_sat", 32'(b_err), 32'd31);
    chk("b_first_fail", 32'(b_ff), 32'd0);
    chk("b_fail_valid", 32'(b_fv), 32'd1);
    chk("b_pass", 32'(b_pass), 32'd0);

    // Zero settle, two loops, stray START pulses while busy.
    run_dut(2, 0, 129, 1'b1, lat, terr);
    chk("c_latency", 32'(lat), 32'd129);
    chk("c_trace", 32'(terr), 32'd0);
    chk("c_pass", 32'(c_pass), 32'd1);
    chk("c_err_cnt", 32'(c_err), 32'd0);

    // Registered DUT without settle time must be caught.
    run_dut(3, 0, 65, 1'b0, lat, terr);
    chk("d_latency", 32'(lat), 32'd65);
    chk("d_err_nonzero", 32'(d_err != 8'd0), 32'd1);
    chk("d_pass", 32'(d_pass), 32'd0);

    // Reset in the middle of vector 30 during a failing run.
    mode_a = 1;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    waited = 0;
    while (a_stim != 6'd30 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("reach_vec30", 32'(a_stim), 32'd30);
    chk("midrun_errs", 32'(a_fv), 32'd1);
    rn = 1'b0;
    #1;
    chk("abort_outputs", {a_stim, a_busy, a_done, a_pass, a_err, a_fv, a_ff}, 32'd0);
    repeat (2) @(negedge clk);
    rn = 1'b1;
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_done || a_busy) ndone++;
    end
    chk("no_done_after_abort", 32'(ndone), 32'd0);
    mode_a = 0;
    run_dut(0, 1, 129, 1'b0, lat, terr);
    chk("post_reset_latency", 32'(lat), 32'd129);
    chk("post_reset_pass", 32'(a_pass), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oai222_exhaustive_checker.md
Name: oai222_exhaustive_checker

Overview:
Self-checking stimulus driver for the 6-input OAI222 complex-gate cell, used in library characterization and silicon-bringup test harnesses. It drives every combination of A1,A2,B1,B2,C1,C2 into a device under test (DUT) and samples the DUT's ZN after a programmable settle time. It compares ZN against the golden function ZN = ~((A1|A2)&(B1|B2)&(C1|C2)) and reports pass/fail, an error count and the first failing vector.

Parameters:
SETTLE_CYCLES, 1, extra cycles each vector is held before ZN is sampled; legal range 0..15.
LOOPS, 1, number of full 64-vector sweeps per START; legal range 1..255.
CNT_W, 8, width of the saturating error counter.

Ports:
CLK  input  1  rising-edge clock.
RN  input  1  asynchronous active-low reset.
START  input  1  begins a run; sampled only in IDLE.
ZN  input  1  DUT output under test.
A1, A2, B1, B2, C1, C2  output  1 each  registered DUT stimulus.
BUSY  output  1  high while a run is in progress.
DONE  output  1  single-cycle pulse when a run completes.
PASS  output  1  high if the last completed run had zero errors; held until the next START or reset.
ERR_CNT  output  CNT_W  number of mismatches in the current/last run; saturates at 2^CNT_W-1.
FAIL_VALID  output  1  at least one mismatch seen in the current/last run.
FIRST_FAIL  output  6  vector index of the first mismatch; valid when FAIL_VALID=1.

Behaviour:
- Clock and reset: one clock, CLK. Reset RN is asynchronous and active-low. While RN=0, every output is 0 and the FSM is in IDLE.
- Vector encoding: vec[5:0] = {A1,A2,B1,B2,C1,C2}. Stimulus outputs are registered directly from vec. They are 0 in IDLE and FINISH.
- FSM states: IDLE, HOLD, CHECK, FINISH.
  - IDLE & START: vec=0, loop=0, hold counter=0. Clear ERR_CNT, FAIL_VALID, FIRST_FAIL and PASS. Go to HOLD. BUSY=1 from the next cycle.
  - HOLD: counts SETTLE_CYCLES cycles, then goes to CHECK. If SETTLE_CYCLES=0, HOLD lasts 0 cycles and CHECK is entered directly.
  - CHECK (1 cycle): ZN is compared with golden(vec).
    - On mismatch: ERR_CNT increments (saturating). If FAIL_VALID=0, FIRST_FAIL<=vec and FAIL_VALID<=1.
    - If vec=63 and loop=LOOPS-1: go to FINISH.
    - Else: vec<=vec+1, wrapping 63->0 with loop<=loop+1, and go to HOLD.
  - FINISH (1 cycle): DONE=1, PASS<=(ERR_CNT==0 including the final CHECK), BUSY=0. Go to IDLE.
- Timing: each vector is applied for exactly SETTLE_CYCLES+1 cycles. ZN is sampled at the last edge of that window.
- Run length: START accepted at edge k gives DONE high in the cycle beginning at edge k+64*LOOPS*(SETTLE_CYCLES+1)+1.
- START handling: START while BUSY or during FINISH is ignored. START held high in IDLE after FINISH starts a new run.
- X/Z handling: in simulation, an X or Z on ZN counts as a mismatch (case-inequality compare).
- Reset during a run: abort immediately. All outputs return to their reset values and no DONE is produced.
- Error counter: ERR_CNT never wraps.
- Golden-function facts: golden=0 for 27 vectors and 1 for 37.

Decomposition:
- Shared package oai222_chk_pkg contains:
  - VEC_W=6 and NUM_VEC=64.
  - The state enum {IDLE,HOLD,CHECK,FINISH}.
  - A function golden_oai222(vec) returning the expected ZN.
- One natural sub-module: oai222_chk_seq, which holds the hold counter, vec and loop counters and produces the CHECK strobe.
- The top level holds the compare logic and the result registers.

Test Plan:
1. Ideal OAI222 model on ZN, SETTLE_CYCLES=1, LOOPS=1, pulse START -> DONE exactly 129 cycles after the accepting edge; PASS=1, ERR_CNT=0, FAIL_VALID=0.
2. ZN tied 1 -> ERR_CNT=27, FAIL_VALID=1, FIRST_FAIL=21 (6'b010101), PASS=0.
3. ZN tied 0, CNT_W=5 -> FIRST_FAIL=0, ERR_CNT saturates at 31 (true count 37), PASS=0.
4. RN asserted during vector 30 -> all outputs 0 immediately and no DONE; after release, START -> full clean run with PASS=1.
5. SETTLE_CYCLES=0, LOOPS=2, ideal DUT -> DONE 129 cycles after START; extra START pulses while BUSY ignored; stimulus outputs change every cycle.
6. DUT with one-cycle registered output: SETTLE_CYCLES=0 -> ERR_CNT>0, PASS=0; SETTLE_CYCLES=1 -> PASS=1.
